pdm_demod: RTL and testbench

//  Pulse-density demodulator: recovers multi-bit unsigned PCM samples from a 1-bit PDM stream.

---
 rtl/pdm_pkg.sv | 12 +
 rtl/cic_comb.sv | 26 ++
 rtl/pdm_demod.sv | 87 ++++++++
 tb/tb_pdm_demod.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: width helpers shared by the PDM demodulator
package pdm_pkg;
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int cic_width(input int order, input int decim);
    return order * log2(decim);
  endfunction
endpackage

// File: rtl/cic_comb.sv
// cic_comb: one CIC differentiator stage that only advances on a valid input
module cic_comb #(
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] x,
  input  logic         x_valid,
  output logic [W-1:0] y,
  output logic         y_valid
);
  logic [W-1:0] z;
  always_ff @(posedge clock) begin
    if (!reset) begin
      z       <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= x_valid;
      if (x_valid) begin
        y <= x - z;
        z <= x;
      end
    end
  end
endmodule

// File: rtl/pdm_demod.sv
// pdm_demod: CIC decimator turning a 1-bit PDM stream into unsigned PCM samples
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int ORDER = 4,
  parameter int DECIM = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid
);
  localparam int G  = cic_width(ORDER, DECIM);
  localparam int W  = G + 1;
  localparam int CW = log2(DECIM);
  localparam int WW = log2(ORDER + 1);
  if (DECIM < 2 || (1 << CW) != DECIM) begin : g_chk_decim
    $error("pdm_demod: DECIM must be a power of two >= 2");
  end
  if (NBITS > G) begin : g_chk_nbits
    $error("pdm_demod: NBITS exceeds CIC growth");
  end
  if (ORDER < 1 || ORDER > 6) begin : g_chk_order
    $error("pdm_demod: ORDER must be 1..6");
  end
  // Whole integrator cascade ripples in one cycle so each stage sees its predecessor's new value
  for (genvar k = 0; k < ORDER; k++) begin : g_int
    logic [W-1:0] acc, nxt;
    if (k == 0) begin : g_first
      assign nxt = acc + W'(din);
    end else begin : g_rest
      assign nxt = acc + g_int[k-1].nxt;
    end
    always_ff @(posedge clock) begin
      if (!reset) acc <= '0;
      else if (din_valid) acc <= nxt;
    end
  end
  logic [CW-1:0] cnt;
  logic [W-1:0]  snap;
  logic          snap_valid;
  logic          dec_hit;
  assign dec_hit = din_valid && cnt == CW'(DECIM - 1);
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt        <= '0;
      snap       <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= dec_hit;
      if (din_valid) cnt <= cnt + 1'b1;
      if (dec_hit) snap <= g_int[ORDER-1].nxt;
    end
  end
  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    logic [W-1:0] y;
    logic         yv;
    if (k == 0) begin : g_first
      cic_comb #(.W(W)) u_comb (.clock(clock), .reset(reset), .x(snap), .x_valid(snap_valid),
                                .y(y), .y_valid(yv));
    end else begin : g_rest
      cic_comb #(.W(W)) u_comb (.clock(clock), .reset(reset), .x(g_comb[k-1].y),
                                .x_valid(g_comb[k-1].yv), .y(y), .y_valid(yv));
    end
  end
  logic [W-1:0]  r;
  logic          rv, live;
  logic [WW-1:0] warm;
  assign r    = g_comb[ORDER-1].y;
  assign rv   = g_comb[ORDER-1].yv;
  assign live = rv && warm == WW'(ORDER);
  // r never exceeds 2^G, so its top bit alone marks the full-scale case
  always_ff @(posedge clock) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      warm       <= '0;
    end else begin
      dout_valid <= live;
      if (rv && !live) warm <= warm + 1'b1;
      if (live) dout <= r[G] ? '1 : r[G-1 -: NBITS];
    end
  end
endmodule

// File: tb/tb_pdm_demod.sv
// tb_pdm_demod: scoreboard bench for the PDM demodulator plus a modulator loopback instance
module tb_pdm_demod;
  logic clock = 1'b0, reset = 1'b0, din = 1'b0, din_valid = 1'b0;
  logic din_b = 1'b0, din_valid_b = 1'b0, loop_on = 1'b0;
  logic [11:0] dout;
  logic        dout_valid;
  logic [15:0] dout_b;
  logic        dout_valid_b;
  logic [15:0] mod_acc = '0;
  typedef struct {int val; int due;} exp_t;
  exp_t sb[$];
  int passed = 0, total = 0, edges = 0, rel = 0, n_in = 0, exp_val = 0, spacing = 16;
  int last_pulse = -1, first_pulse = -1, npulse = 0, nb = 0;
  always #5 clock = ~clock;
  pdm_demod #(.NBITS(12), .ORDER(3), .DECIM(16)) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid));
  pdm_demod #(.NBITS(16), .ORDER(4), .DECIM(16)) dut_loop (
    .clock(clock), .reset(reset), .din(din_b), .din_valid(din_valid_b),
    .dout(dout_b), .dout_valid(dout_valid_b));
  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    total++;
    if ((got > exp ? got - exp : exp - got) <= tol) passed++;
    else $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
  endtask
  task automatic step(input logic d, input logic v, input logic r);
    logic [16:0] s;
    int cyc;
    exp_t e;
    s = {1'b0, mod_acc} + 17'h4000;
    din = d;
    din_valid = v;
    reset = r;
    din_b = s[16];
    din_valid_b = loop_on & r;
    @(posedge clock);
    #1;
    edges++;
    if (din_valid_b) mod_acc = s[15:0];
    if (!r) begin
      sb.delete();
      n_in = 0;
      rel = edges;
      last_pulse = -1;
      first_pulse = -1;
      npulse = 0;
      nb = 0;
      mod_acc = '0;
    end
    if (dout_valid) begin
      cyc = edges - rel + 1;
      npulse++;
      if (sb.size() == 0) chk("spurious_pulse", 1, 0);
      else begin
        e = sb.pop_front();
        chk("dout", int'(dout), e.val);
        chk("latency", cyc, e.due);
      end
      if (last_pulse >= 0) chk("spacing", cyc - last_pulse, spacing);
      if (first_pulse < 0) first_pulse = cyc;
      last_pulse = cyc;
    end
    if (dout_valid_b && loop_on) begin
      nb++;
      chk("loopback", int'(dout_b), 16'h4000, 16'h0100);
    end
    if (r && v) begin
      n_in++;
      if (n_in % 16 == 0 && n_in > 48) sb.push_back('{exp_val, edges - rel + 5});
    end
  endtask
  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_dout_b", int'(dout_b), 0);
  endtask
  task automatic flush(input int pulses, input int first);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    chk("sb_empty", sb.size(), 0);
    chk("pulse_count", npulse, pulses);
    if (first > 0) chk("first_pulse", first_pulse, first);
  endtask
  initial begin
    // all ones saturates at full scale
    exp_val = 4095; spacing = 16;
    do_reset();
    repeat (16 * 12) step(1'b1, 1'b1, 1'b1);
    flush(9, 69);
    // all zeros, first pulse on the 4th decimation event
    exp_val = 0;
    do_reset();
    repeat (16 * 8) step(1'b0, 1'b1, 1'b1);
    flush(5, 64 + 3 + 2);
    // alternating bits decode to exactly half scale
    exp_val = 2048;
    do_reset();
    for (int i = 0; i < 16 * 10; i++) step(i % 2 == 0, 1'b1, 1'b1);
    flush(7, 69);
    // stalls between samples are transparent; only the pulse spacing stretches
    spacing = 96;
    do_reset();
    for (int i = 0; i < 16 * 8; i++) begin
      step(i % 2 == 0, 1'b1, 1'b1);
      repeat (5) step(1'($urandom_range(1)), 1'b0, 1'b1);
    end
    flush(5, 6 * 63 + 1 + 5);
    // loopback through a first-order modulator at quarter scale
    loop_on = 1'b1;
    do_reset();
    repeat (16 * 20) step(1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    chk("loop_pulses", nb, 16);
    loop_on = 1'b0;
    // a one-cycle reset mid-stream drops the in-flight sample and restarts warm-up
    spacing = 16;
    do_reset();
    for (int i = 0; i < 98; i++) step(i % 2 == 0, 1'b1, 1'b1);
    chk("pre_reset_dout", int'(dout), 2048);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_reset_dout", int'(dout), 0);
    chk("mid_reset_valid", int'(dout_valid), 0);
    for (int i = 0; i < 16 * 6; i++) step(i % 2 == 0, 1'b1, 1'b1);
    flush(3, 69);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
